decode_stage: RTL and testbench

//  D stage of the 5-stage MIPS pipeline; consumes IRD/PC8D from the F stage and returns NPC/NPC_Sel/Branch to it.

---
 rtl/mips_defs.sv | 26 ++
 rtl/fwd_mux5.sv | 26 ++
 rtl/decode_stage.sv | 109 ++++++++++
 tb/tb_decode_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS encodings: opcodes, functs, next-PC selects and forward-select codes.
// Used by the F stage, decode_stage and the hazard unit.
package mips_defs;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [1:0] NPC_SEL_PC4 = 2'd0;
    localparam logic [1:0] NPC_SEL_J   = 2'd1;
    localparam logic [1:0] NPC_SEL_BR  = 2'd2;
    localparam logic [1:0] NPC_SEL_JR  = 2'd3;

    localparam logic [2:0] FWD_RF    = 3'd0;
    localparam logic [2:0] FWD_PC8E  = 3'd1;
    localparam logic [2:0] FWD_AO    = 3'd2;
    localparam logic [2:0] FWD_PC8M  = 3'd3;
    localparam logic [2:0] FWD_WD    = 3'd4;
endpackage

// File: rtl/fwd_mux5.sv
// 5:1 operand forwarding mux; unused select codes fall back to register-file data.
module fwd_mux5
    import mips_defs::*;
#(
    parameter int DW    = 32,
    parameter int FWD_W = 3
) (
    input  logic [FWD_W-1:0] sel,
    input  logic [DW-1:0]    rf,
    input  logic [DW-1:0]    pc8_e,
    input  logic [DW-1:0]    ao,
    input  logic [DW-1:0]    pc8_m,
    input  logic [DW-1:0]    wd,
    output logic [DW-1:0]    out
);
    always_comb begin
        out = rf;
        case (sel)
            FWD_PC8E: out = pc8_e;
            FWD_AO:   out = ao;
            FWD_PC8M: out = pc8_m;
            FWD_WD:   out = wd;
            default:  out = rf;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// MIPS D stage: decode, forwarded branch compare, branch/jump targets, and the D/E register.
// A stalled D sends a bubble into E while still tracing PC8D.
module decode_stage
    import mips_defs::*;
#(
    parameter int DW    = 32,
    parameter int FWD_W = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [DW-1:0]    IRD,
    input  logic [DW-1:0]    PC8D,
    input  logic             StallD,
    input  logic [DW-1:0]    RF_RD1,
    input  logic [DW-1:0]    RF_RD2,
    input  logic [FWD_W-1:0] Forward_RS_D_Sel,
    input  logic [FWD_W-1:0] Forward_RT_D_Sel,
    input  logic [DW-1:0]    PC8fromE,
    input  logic [DW-1:0]    AO,
    input  logic [DW-1:0]    PC8fromM,
    input  logic [DW-1:0]    MUX_RF_WD_OUT,
    output logic [4:0]       RF_A1,
    output logic [4:0]       RF_A2,
    output logic [DW-1:0]    NPC,
    output logic [1:0]       NPC_Sel,
    output logic             Branch,
    output logic [DW-1:0]    IRE,
    output logic [DW-1:0]    PC8E,
    output logic [DW-1:0]    RSE,
    output logic [DW-1:0]    RTE,
    output logic [DW-1:0]    EXTE
);
    logic [DW-1:0] rs_fwd, rt_fwd, pc4, br_target, j_target, ext;
    logic [5:0]    op, fn;
    logic [15:0]   imm;

    assign op    = IRD[31:26];
    assign fn    = IRD[5:0];
    assign imm   = IRD[15:0];
    assign RF_A1 = IRD[25:21];
    assign RF_A2 = IRD[20:16];

    fwd_mux5 #(.DW(DW), .FWD_W(FWD_W)) u_rs_mux (
        .sel(Forward_RS_D_Sel), .rf(RF_RD1), .pc8_e(PC8fromE), .ao(AO),
        .pc8_m(PC8fromM), .wd(MUX_RF_WD_OUT), .out(rs_fwd)
    );
    fwd_mux5 #(.DW(DW), .FWD_W(FWD_W)) u_rt_mux (
        .sel(Forward_RT_D_Sel), .rf(RF_RD2), .pc8_e(PC8fromE), .ao(AO),
        .pc8_m(PC8fromM), .wd(MUX_RF_WD_OUT), .out(rt_fwd)
    );

    assign pc4       = PC8D - DW'(4);
    assign br_target = pc4 + {{(DW-18){imm[15]}}, imm, 2'b00};
    assign j_target  = {pc4[DW-1:DW-4], IRD[25:0], 2'b00};

    always_comb begin
        NPC_Sel = NPC_SEL_PC4;
        case (op)
            OP_J, OP_JAL:   NPC_Sel = NPC_SEL_J;
            OP_BEQ, OP_BNE: NPC_Sel = NPC_SEL_BR;
            OP_SPECIAL:     if (fn == FN_JR || fn == FN_JALR) NPC_Sel = NPC_SEL_JR;
            default:        NPC_Sel = NPC_SEL_PC4;
        endcase
    end

    // jr/jalr targets are resolved in F, so they fall through to PC8D here.
    always_comb begin
        NPC = PC8D;
        case (NPC_Sel)
            NPC_SEL_J:  NPC = j_target;
            NPC_SEL_BR: NPC = br_target;
            default:    NPC = PC8D;
        endcase
    end

    assign Branch = ((op == OP_BEQ) && (rs_fwd == rt_fwd)) ||
                    ((op == OP_BNE) && (rs_fwd != rt_fwd));

    always_comb begin
        ext = {{(DW-16){imm[15]}}, imm};
        case (op)
            OP_ORI, OP_ANDI: ext = {{(DW-16){1'b0}}, imm};
            OP_LUI:          ext = {imm, {(DW-16){1'b0}}};
            default:         ext = {{(DW-16){imm[15]}}, imm};
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            IRE  <= '0;
            PC8E <= '0;
            RSE  <= '0;
            RTE  <= '0;
            EXTE <= '0;
        end else if (StallD) begin
            IRE  <= '0;
            PC8E <= PC8D;
            RSE  <= '0;
            RTE  <= '0;
            EXTE <= '0;
        end else begin
            IRE  <= IRD;
            PC8E <= PC8D;
            RSE  <= rs_fwd;
            RTE  <= rt_fwd;
            EXTE <= ext;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage against a behavioural D-stage model.
module tb_decode_stage;
    logic        Clk = 1'b0;
    logic        Reset, StallD;
    logic [31:0] IRD, PC8D, RF_RD1, RF_RD2, PC8fromE, AO, PC8fromM, MUX_RF_WD_OUT;
    logic [2:0]  Forward_RS_D_Sel, Forward_RT_D_Sel;
    logic [4:0]  RF_A1, RF_A2;
    logic [31:0] NPC, IRE, PC8E, RSE, RTE, EXTE;
    logic [1:0]  NPC_Sel;
    logic        Branch;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .Clk(Clk), .Reset(Reset), .IRD(IRD), .PC8D(PC8D), .StallD(StallD),
        .RF_RD1(RF_RD1), .RF_RD2(RF_RD2),
        .Forward_RS_D_Sel(Forward_RS_D_Sel), .Forward_RT_D_Sel(Forward_RT_D_Sel),
        .PC8fromE(PC8fromE), .AO(AO), .PC8fromM(PC8fromM), .MUX_RF_WD_OUT(MUX_RF_WD_OUT),
        .RF_A1(RF_A1), .RF_A2(RF_A2), .NPC(NPC), .NPC_Sel(NPC_Sel), .Branch(Branch),
        .IRE(IRE), .PC8E(PC8E), .RSE(RSE), .RTE(RTE), .EXTE(EXTE)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input int sel, input logic [31:0] rf);
        case (sel)
            1: return PC8fromE;
            2: return AO;
            3: return PC8fromM;
            4: return MUX_RF_WD_OUT;
            default: return rf;
        endcase
    endfunction

    // Reference model, written from the instruction-set rules.
    logic [31:0] m_npc, m_rs, m_rt, m_ext;
    logic [1:0]  m_sel;
    logic        m_br;

    task automatic model();
        int unsigned op, fn;
        logic [31:0] pc4, simm;
        op   = IRD >> 26;
        fn   = IRD & 32'h3F;
        pc4  = PC8D - 32'd4;
        simm = 32'($signed(IRD[15:0]));
        m_rs = pick(int'(Forward_RS_D_Sel), RF_RD1);
        m_rt = pick(int'(Forward_RT_D_Sel), RF_RD2);
        if (op == 2 || op == 3)            m_sel = 2'd1;
        else if (op == 4 || op == 5)       m_sel = 2'd2;
        else if (op == 0 && (fn == 8 || fn == 9)) m_sel = 2'd3;
        else                               m_sel = 2'd0;
        if (m_sel == 2'd1)      m_npc = (pc4 & 32'hF000_0000) + (IRD & 32'h03FF_FFFF) * 4;
        else if (m_sel == 2'd2) m_npc = pc4 + simm * 4;
        else                    m_npc = PC8D;
        m_br = (op == 4 && m_rs == m_rt) || (op == 5 && m_rs != m_rt);
        if (op == 12 || op == 13) m_ext = IRD & 32'hFFFF;
        else if (op == 15)        m_ext = (IRD & 32'hFFFF) * 65536;
        else                      m_ext = simm;
    endtask

    // One clock: check combinational outputs, then the D/E register after the edge.
    task automatic step(input string tag);
        logic [31:0] e_ir, e_pc, e_rs, e_rt, e_ext;
        #1;
        model();
        chk({tag, "_npc"}, NPC, m_npc);
        chk({tag, "_sel"}, 32'(NPC_Sel), 32'(m_sel));
        chk({tag, "_br"}, 32'(Branch), 32'(m_br));
        chk({tag, "_a1"}, 32'(RF_A1), (IRD >> 21) & 32'h1F);
        chk({tag, "_a2"}, 32'(RF_A2), (IRD >> 16) & 32'h1F);
        if (Reset)       begin e_ir = 0;   e_pc = 0;    e_rs = 0;    e_rt = 0;    e_ext = 0;     end
        else if (StallD) begin e_ir = 0;   e_pc = PC8D; e_rs = 0;    e_rt = 0;    e_ext = 0;     end
        else             begin e_ir = IRD; e_pc = PC8D; e_rs = m_rs; e_rt = m_rt; e_ext = m_ext; end
        @(posedge Clk);
        #1;
        chk({tag, "_ire"}, IRE, e_ir);
        chk({tag, "_pc8e"}, PC8E, e_pc);
        chk({tag, "_rse"}, RSE, e_rs);
        chk({tag, "_rte"}, RTE, e_rt);
        chk({tag, "_exte"}, EXTE, e_ext);
    endtask

    function automatic logic [31:0] rand_ir();
        int unsigned ops [12] = '{0, 2, 3, 4, 5, 12, 13, 15, 8, 35, 43, 63};
        int unsigned op, fn;
        logic [31:0] ir;
        op = ops[$urandom_range(0, 11)];
        ir = $urandom;
        ir[31:26] = 6'(op);
        if (op == 0) begin
            fn = $urandom_range(0, 3);
            ir[5:0] = (fn == 0) ? 6'h08 : (fn == 1) ? 6'h09 : (fn == 2) ? 6'h21 : 6'($urandom);
        end
        return ir;
    endfunction

    initial begin
        Reset = 1; StallD = 0; IRD = 32'h1234_5678; PC8D = 32'h3008;
        RF_RD1 = 0; RF_RD2 = 0; Forward_RS_D_Sel = 0; Forward_RT_D_Sel = 0;
        PC8fromE = 32'h1111_0000; AO = 0; PC8fromM = 32'h2222_0000; MUX_RF_WD_OUT = 32'h4444_0000;
        step("reset");
        chk("reset_ire", IRE, 32'h0);
        Reset = 0;

        // beq taken
        IRD = 32'h1085_0003; PC8D = 32'h3008; RF_RD1 = 5; RF_RD2 = 5;
        #1;
        chk("t1_sel", 32'(NPC_Sel), 32'd2);
        chk("t1_br", 32'(Branch), 32'd1);
        chk("t1_npc", NPC, 32'h3010);
        step("t1");

        // jal
        IRD = 32'h0C00_0C04; PC8D = 32'h3008;
        #1;
        chk("t2_sel", 32'(NPC_Sel), 32'd1);
        chk("t2_npc", NPC, 32'h3010);
        step("t2");
        chk("t2_ire", IRE, 32'h0C00_0C04);
        chk("t2_pc8e", PC8E, 32'h3008);

        // bne with forwarded rs
        IRD = 32'h1485_0001; Forward_RS_D_Sel = 2; AO = 32'h3030; RF_RD1 = 32'h3060; RF_RD2 = 32'h3030;
        #1;
        chk("t3_br_fwd", 32'(Branch), 32'd0);
        step("t3a");
        Forward_RS_D_Sel = 0;
        #1;
        chk("t3_br_rf", 32'(Branch), 32'd1);
        step("t3b");

        // ori held for two stalled cycles, then released
        IRD = 32'h3421_1234; StallD = 1;
        step("t4s1");
        chk("t4_bubble1", IRE, 32'h0);
        step("t4s2");
        chk("t4_bubble2", IRE, 32'h0);
        StallD = 0;
        step("t4go");
        chk("t4_ire", IRE, 32'h3421_1234);
        chk("t4_exte", EXTE, 32'h0000_1234);

        // lui then jr
        IRD = 32'h3C01_8000;
        step("t5lui");
        chk("t5_exte", EXTE, 32'h8000_0000);
        IRD = 32'h03E0_0008;
        #1;
        chk("t5_sel", 32'(NPC_Sel), 32'd3);
        chk("t5_br", 32'(Branch), 32'd0);
        step("t5jr");

        // reset with a valid instruction, including mid-stall
        IRD = 32'h3421_1234; Reset = 1;
        step("t6rst");
        chk("t6_ire", IRE, 32'h0);
        Reset = 0;
        step("t6go");
        chk("t6_resume", IRE, 32'h3421_1234);
        StallD = 1; Reset = 1;
        step("t6rststall");
        chk("t6_pc8e", PC8E, 32'h0);
        Reset = 0; StallD = 0; IRD = 0;
        step("nop");

        for (int i = 0; i < 300; i++) begin
            IRD = rand_ir();
            PC8D = $urandom;
            RF_RD1 = $urandom;
            RF_RD2 = ($urandom_range(0, 2) == 0) ? RF_RD1 : $urandom;
            AO = ($urandom_range(0, 3) == 0) ? RF_RD2 : $urandom;
            PC8fromE = $urandom; PC8fromM = $urandom; MUX_RF_WD_OUT = $urandom;
            Forward_RS_D_Sel = 3'($urandom_range(0, 7));
            Forward_RT_D_Sel = 3'($urandom_range(0, 7));
            StallD = ($urandom_range(0, 3) == 0);
            Reset = ($urandom_range(0, 19) == 0);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
